adc_channel_scheduler: RTL and testbench
========================================

// Module: adc_channel_scheduler
// PURPOSE
//  Round-robin scheduler that time-shares one ADC post-processing chain (decimator, comparators, calibration) between N ADC channels.
//  Each channel owns a 1-deep capture buffer. Captured samples are granted one per cycle to a registered output stream.
//  out_dest carries the channel index, so downstream logic can demultiplex the result.
//  Sits between the ADC interface cores and the shared processing datapath.
// PARAMETERS
//  N_CHANNELS  4   number of requesting ADC channels (2..16)
//  DATA_WIDTH  16  sample width in bits
//  DEST_WIDTH  4   width of out_dest; must be >= $clog2(N_CHANNELS)
// PORTS
//  clock          in   1              system clock
//  reset          in   1              synchronous, active-low reset
//  in_data        in   N*DATA_WIDTH   channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
//  in_valid       in   N              per-channel sample valid
//  in_ready       out  N              per-channel ready (capture buffer empty, or channel disabled)
//  channel_enable in   N              per-channel enable mask
//  clear_overrun  in   1              single-cycle pulse; clears all overrun flags
//  overrun        out  N              sticky flag: channel k presented a sample while in_ready[k]=0
//  out_data       out  DATA_WIDTH     granted sample
//  out_dest       out  DEST_WIDTH     index of the granted channel
//  out_valid      out  1              output stream valid
//  out_ready      in   1              output stream ready from the processing chain
// BEHAVIOUR
//  Reset (reset=0 at a clock edge):
//   - all buffers empty; out_valid=0; out_data=0; out_dest=0; overrun=0.
//   - round-robin pointer = N_CHANNELS-1, so channel 0 has first priority.
//   - in_ready is combinational: while reset=0, in_ready=0 for every channel.
//  Capture:
//   - Enabled channel, in_valid[k] && in_ready[k] -> buffer k loads in_data[k]; it is full from the next cycle.
//   - in_ready[k] = !full[k] || !channel_enable[k].
//   - Disabled channel: input is accepted and dropped; no capture, no overrun.
//  Overrun:
//   - Enabled channel with in_valid[k] && !in_ready[k] -> overrun[k] set next cycle. The sample is dropped; the buffer keeps its old sample.
//   - clear_overrun has priority over a set in the same cycle; the flag reads 0 the next cycle.
//  Disable while full:
//   - channel_enable[k]=0 with buffer k full -> buffer k is flushed next cycle.
//   - A sample already in the output register is still delivered.
//  Grant:
//   - The output register can load when !out_valid || out_ready (full-throughput pipe).
//   - When it can load, the winner is the first full, enabled buffer found searching from pointer+1 upward, wrapping modulo N.
//   - On a grant: out_data <= buffer, out_dest <= k, out_valid <= 1, buffer k empties, pointer <= k.
//   - No full buffer and out_ready=1 -> out_valid <= 0.
//   - If out_valid=1 and out_ready=0: out_data and out_dest are held, and no grant is made.
//  Simultaneous events:
//   - Buffer k is granted and in_valid[k] in the same cycle: in_ready[k] is 0 that cycle (buffer still full), so the sample counts as an overrun.
//   - Sources must therefore hold valid for one more cycle (AXI-stream rule). This is not a bypass path.
//  Latency: capture at edge t -> out_valid at edge t+1 when output is free. Minimum 1 cycle from accept to output.
//  Fairness: with all N buffers continuously full and out_ready=1, each channel gets exactly 1 grant per N cycles.
//  Throughput: at most 1 sample per cycle in total.
//  Reset mid-operation:
//   - Buffered and in-flight samples are discarded; out_valid=0 at the next edge.
//   - No partial beat is emitted.
// TESTING
//  1 Reset: drive in_valid=all-1, reset=0 for 3 cycles.
//    -> in_ready=0, out_valid=0, overrun=0 throughout.
//  2 Round robin, N=4, all enabled: load buffers with 0x0100,0x0101,0x0102,0x0103; hold out_ready=1.
//    -> out_dest sequence 0,1,2,3 on 4 consecutive cycles with the matching data; then out_valid=0.
//  3 Backpressure: out_ready=0 for 5 cycles with channels 1 and 2 full.
//    -> out_data/out_dest stable, no grant; on release, dest 1 then dest 2.
//  4 Overrun: channel 2 full and not granted (out_ready=0); second sample 0x7FFF on ch2.
//    -> overrun[2]=1, buffer keeps its old value; a clear_overrun pulse -> overrun[2]=0 next cycle.
//  5 Disable: channel_enable[3]=0 while buffer 3 is full.
//    -> dest 3 is never emitted; in_ready[3]=1; samples on ch3 are dropped with no overrun.
//  6 Fairness soak: all channels valid every cycle, out_ready random at 50%, 10k cycles.
//    -> per-channel grant counts differ by <=1 at end; scoreboard shows no duplicated or reordered samples.

Source files
------------

// File: rtl/adc_channel_scheduler.sv
// Round-robin scheduler that time-shares one ADC post-processing chain between N channels.
// Each channel has a 1-deep capture buffer; one buffered sample per cycle moves to a registered output.
module adc_channel_scheduler #(
    parameter int unsigned N_CHANNELS = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEST_WIDTH = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [N_CHANNELS*DATA_WIDTH-1:0] in_data,
    input  logic [N_CHANNELS-1:0]            in_valid,
    output logic [N_CHANNELS-1:0]            in_ready,
    input  logic [N_CHANNELS-1:0]            channel_enable,
    input  logic                             clear_overrun,
    output logic [N_CHANNELS-1:0]            overrun,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [DEST_WIDTH-1:0]            out_dest,
    output logic                             out_valid,
    input  logic                             out_ready
);

    localparam int unsigned PTR_W = $clog2(N_CHANNELS);

    logic [N_CHANNELS-1:0] full_q;
    logic [DATA_WIDTH-1:0] buf_q [N_CHANNELS];
    logic [PTR_W-1:0]      ptr_q;
    logic [N_CHANNELS-1:0] overrun_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [DEST_WIDTH-1:0] out_dest_q;
    logic                  out_valid_q;

    logic                  can_load;
    logic [N_CHANNELS-1:0] eligible;
    logic                  grant_any;
    logic [PTR_W-1:0]      grant_idx;
    logic [N_CHANNELS-1:0] grant_vec;
    logic [N_CHANNELS-1:0] overrun_set;

    assign can_load    = !out_valid_q || out_ready;
    assign eligible    = full_q & channel_enable;
    assign in_ready    = reset ? (~full_q | ~channel_enable) : '0;
    // A full buffer cannot accept, even in the cycle it is being granted.
    assign overrun_set = channel_enable & in_valid & full_q;

    // Walk from ptr+N down to ptr+1 so the candidate nearest ptr+1 wins.
    always_comb begin
        int unsigned cand;
        logic [PTR_W-1:0] cand_idx;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned i = N_CHANNELS; i >= 1; i--) begin
            cand = 32'(ptr_q) + i;
            if (cand >= N_CHANNELS) begin
                cand = cand - N_CHANNELS;
            end
            cand_idx = PTR_W'(cand);
            if (eligible[cand_idx]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    assign grant_vec = (can_load && grant_any) ? (N_CHANNELS'(1) << grant_idx) : '0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            full_q      <= '0;
            overrun_q   <= '0;
            ptr_q       <= PTR_W'(N_CHANNELS - 1);
            out_data_q  <= '0;
            out_dest_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            for (int k = 0; k < N_CHANNELS; k++) begin
                if (!channel_enable[k] || grant_vec[k]) begin
                    full_q[k] <= 1'b0;
                end else if (in_valid[k] && !full_q[k]) begin
                    full_q[k] <= 1'b1;
                    buf_q[k]  <= in_data[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end

            if (clear_overrun) begin
                overrun_q <= '0;
            end else begin
                overrun_q <= overrun_q | overrun_set;
            end

            if (can_load) begin
                if (grant_any) begin
                    out_data_q  <= buf_q[grant_idx];
                    out_dest_q  <= DEST_WIDTH'(grant_idx);
                    out_valid_q <= 1'b1;
                    ptr_q       <= grant_idx;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

    assign overrun   = overrun_q;
    assign out_data  = out_data_q;
    assign out_dest  = out_dest_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adc_channel_scheduler.sv
// Bench for adc_channel_scheduler: directed scenarios with literal expectations, then random
// traffic and a fairness soak checked every cycle against a behavioural model.
module tb_adc_channel_scheduler;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int DS = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [N*DW-1:0]   in_data;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic [N-1:0]      channel_enable;
    logic              clear_overrun;
    logic [N-1:0]      overrun;
    logic [DW-1:0]     out_data;
    logic [DS-1:0]     out_dest;
    logic              out_valid;
    logic              out_ready;

    adc_channel_scheduler #(
        .N_CHANNELS(N),
        .DATA_WIDTH(DW),
        .DEST_WIDTH(DS)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .channel_enable (channel_enable),
        .clear_overrun  (clear_overrun),
        .overrun        (overrun),
        .out_data       (out_data),
        .out_dest       (out_dest),
        .out_valid      (out_valid),
        .out_ready      (out_ready)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Behavioural model state: what the registers must hold after the last edge.
    bit          m_known = 1'b0;
    bit [N-1:0]  m_full;
    logic [DW-1:0] m_buf [N];
    bit [N-1:0]  m_ovr;
    bit          m_ov;
    logic [DW-1:0] m_od;
    logic [DS-1:0] m_dest;
    int          m_ptr;

    bit soak_on = 1'b0;
    int last_seq [N];
    int cnt [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit can;
        int win;
        if (!reset) begin
            m_full  = '0;
            m_ovr   = '0;
            m_ov    = 1'b0;
            m_od    = '0;
            m_dest  = '0;
            m_ptr   = N - 1;
            m_known = 1'b1;
            return;
        end
        can = !m_ov || out_ready;
        win = -1;
        if (can) begin
            for (int d = 1; d <= N; d++) begin
                int c;
                c = (m_ptr + d) % N;
                if (win < 0 && m_full[c] && channel_enable[c]) win = c;
            end
        end
        if (can) begin
            if (win >= 0) begin
                m_od   = m_buf[win];
                m_dest = DS'(win);
                m_ov   = 1'b1;
                m_ptr  = win;
            end else begin
                m_ov = 1'b0;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!channel_enable[k]) begin
                m_full[k] = 1'b0;
            end else if (m_full[k]) begin
                if (in_valid[k]) m_ovr[k] = 1'b1;
                if (k == win) m_full[k] = 1'b0;
            end else if (in_valid[k]) begin
                m_full[k] = 1'b1;
                m_buf[k]  = in_data[k*DW +: DW];
            end
        end
        if (clear_overrun) m_ovr = '0;
    endtask

    // One clock: compare at the falling edge, advance the model, step past the rising edge.
    task automatic tick();
        logic [N-1:0] exp_ready;
        @(negedge clock);
        exp_ready = reset ? (~m_full | ~channel_enable) : '0;
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        if (m_known) begin
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            chk("out_dest", 32'(out_dest), 32'(m_dest));
            chk("out_data", 32'(out_data), 32'(m_od));
            chk("overrun", 32'(overrun), 32'(m_ovr));
        end
        if (soak_on && out_valid && out_ready) begin
            int ch;
            ch = int'(out_dest);
            if (ch < N) begin
                chk("soak_tag", 32'(out_data[15:14]), 32'(ch));
                chk("soak_order", 32'(int'(out_data[13:0]) > last_seq[ch]), 32'd1);
                last_seq[ch] = int'(out_data[13:0]);
                cnt[ch]++;
            end else begin
                chk("soak_dest_range", 32'(ch), 32'd0);
            end
        end
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [DW-1:0] v);
        in_data[k*DW +: DW] = v;
    endtask

    initial begin
        reset          = 1'b0;
        in_data        = '0;
        in_valid       = '1;
        channel_enable = '1;
        clear_overrun  = 1'b0;
        out_ready      = 1'b0;

        // Reset held with every channel presenting data.
        repeat (3) begin
            tick();
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_overrun", 32'(overrun), 32'd0);
        end
        reset = 1'b1;

        // Round robin from channel 0.
        for (int k = 0; k < N; k++) set_ch(k, 16'h0100 + 16'(k));
        in_valid  = '1;
        out_ready = 1'b1;
        tick();
        in_valid = '0;
        for (int k = 0; k < N; k++) begin
            tick();
            chk("rr_valid", 32'(out_valid), 32'd1);
            chk("rr_dest", 32'(out_dest), 32'(k));
            chk("rr_data", 32'(out_data), 32'h0100 + 32'(k));
        end
        tick();
        chk("rr_idle", 32'(out_valid), 32'd0);

        // Backpressure with channels 1 and 2 waiting behind a stalled beat.
        out_ready = 1'b0;
        in_valid  = 4'b0001;
        set_ch(0, 16'h0A00);
        tick();
        in_valid = 4'b0110;
        set_ch(1, 16'h0A01);
        set_ch(2, 16'h0A02);
        tick();
        in_valid = '0;
        repeat (5) begin
            tick();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_dest", 32'(out_dest), 32'd0);
            chk("bp_data", 32'(out_data), 32'h0A00);
            chk("bp_ready", 32'(in_ready), 32'b1001);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_rel1_dest", 32'(out_dest), 32'd1);
        chk("bp_rel1_data", 32'(out_data), 32'h0A01);
        tick();
        chk("bp_rel2_dest", 32'(out_dest), 32'd2);
        chk("bp_rel2_data", 32'(out_data), 32'h0A02);
        tick();
        chk("bp_idle", 32'(out_valid), 32'd0);

        // Overrun on channel 2 while the output is stalled on channel 1.
        out_ready = 1'b0;
        in_valid  = 4'b0110;
        set_ch(1, 16'h0B01);
        set_ch(2, 16'h0B02);
        tick();
        in_valid = '0;
        tick();
        chk("ov_stall_dest", 32'(out_dest), 32'd1);
        in_valid = 4'b0100;
        set_ch(2, 16'h7FFF);
        tick();
        in_valid = '0;
        chk("ov_set", 32'(overrun), 32'b0100);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        chk("ov_clear", 32'(overrun), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("ov_kept_dest", 32'(out_dest), 32'd2);
        chk("ov_kept_data", 32'(out_data), 32'h0B02);
        tick();
        chk("ov_idle", 32'(out_valid), 32'd0);

        // Disable channel 3 while its buffer is full.
        out_ready = 1'b0;
        in_valid  = 4'b1000;
        set_ch(3, 16'h0C03);
        tick();
        chk("dis_full_ready", 32'(in_ready[3]), 32'd0);
        channel_enable = 4'b0111;
        set_ch(3, 16'h0C33);
        #1;
        chk("dis_ready", 32'(in_ready[3]), 32'd1);
        tick();
        chk("dis_no_out", 32'(out_valid), 32'd0);
        chk("dis_no_ovr", 32'(overrun), 32'd0);
        in_valid  = '0;
        out_ready = 1'b1;
        tick();
        channel_enable = '1;
        tick();
        chk("dis_flushed", 32'(out_valid), 32'd0);
        chk("dis_reenable_ready", 32'(in_ready), 32'hF);

        // Random traffic with enables and clears toggling.
        repeat (2000) begin
            in_valid = N'($urandom);
            for (int k = 0; k < N; k++) set_ch(k, DW'($urandom));
            for (int k = 0; k < N; k++) channel_enable[k] = ($urandom_range(0, 7) != 0);
            clear_overrun = ($urandom_range(0, 15) == 0);
            out_ready     = $urandom_range(0, 1) == 1;
            tick();
        end

        // Reset in the middle of traffic.
        clear_overrun  = 1'b0;
        channel_enable = '1;
        in_valid       = '1;
        reset          = 1'b0;
        tick();
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ovr", 32'(overrun), 32'd0);
        reset = 1'b1;

        // Fairness soak: every channel always valid, tagged with channel and cycle number.
        for (int k = 0; k < N; k++) begin
            last_seq[k] = -1;
            cnt[k]      = 0;
        end
        soak_on = 1'b1;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int k = 0; k < N; k++) set_ch(k, {2'(k), 14'(cyc)});
            out_ready = $urandom_range(0, 1) == 1;
            tick();
        end
        soak_on = 1'b0;
        begin
            int mn, mx;
            mn = cnt[0];
            mx = cnt[0];
            for (int k = 1; k < N; k++) begin
                if (cnt[k] < mn) mn = cnt[k];
                if (cnt[k] > mx) mx = cnt[k];
            end
            chk("fair_spread", 32'(mx - mn <= 1), 32'd1);
            chk("fair_active", 32'(mn > 1000), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
